// File: rtl/sid_spi_bus.sv
// sid_spi_bus
//   Bridges spi_slave to sid. Received SPI bytes are decoded as a two-byte
//   write protocol (header 1AAAAADD, then data 0xDDDDDD). Each completed write
//   {addr, data} is queued in a FIFO. At most one entry is issued to the SID
//   per 1 MHz CLKen tick, so burst SPI traffic reaches the SID at bus rate.
//
//   Optional build macro: SID_BUS_STATUS_EN
//     defined   : LEVEL, OVF and ERR are live.
//     undefined : LEVEL, OVF and ERR are tied to 0 and no flag logic is built.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   AW     log2(DEPTH)
//
// Ports
//   CLK        in   system clock (12 MHz)
//   RSTn       in   asynchronous active-low reset
//   SPI_DATA   in   [7:0] byte from spi_slave, valid when SPI_RECV=1
//   SPI_RECV   in   1-cycle strobe qualifying SPI_DATA
//   CLKen      in   1 MHz enable from sid_clk
//   WR         out  1-cycle write strobe to sid (registered)
//   ADDR       out  [4:0] SID register address, held between writes
//   DATAW      out  [7:0] SID write data, held between writes
//   LEVEL      out  [AW:0] FIFO occupancy 0..DEPTH
//   OVF        out  sticky: completed write dropped on a full FIFO
//   ERR        out  sticky: data byte received with no header latched
//   DBG_STATE  out  decoder state (0 = HDR_WAIT, 1 = DATA_WAIT)
//
// Handshake: SPI_RECV is a qualifier-only strobe (no back-pressure); a byte
//   is consumed on every cycle SPI_RECV=1. WR is a single-cycle strobe with
//   ADDR/DATAW valid in the same cycle; the SID has no ready.

module sid_spi_bus #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [7:0]    SPI_DATA,
  input  logic          SPI_RECV,
  input  logic          CLKen,
  output logic          WR,
  output logic [4:0]    ADDR,
  output logic [7:0]    DATAW,
  output logic [AW:0]   LEVEL,
  output logic          OVF,
  output logic          ERR,
  output logic          DBG_STATE
);

  localparam int              EW       = 13;
  localparam logic [AW:0]     LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic {
    HDR_WAIT  = 1'b0,
    DATA_WAIT = 1'b1
  } dec_state_t;

  dec_state_t       r_state, w_state_next;
  logic [4:0]       r_hdr_addr;
  logic [1:0]       r_hdr_msb;
  logic             w_hdr_load;
  logic             w_push;
  logic             w_proto_err;
  logic [EW-1:0]    w_push_entry;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full, w_empty, w_pop, w_push_ok, w_drop;

  logic             r_wr;
  logic [4:0]       r_addr;
  logic [7:0]       r_dataw;

  // Decoder: advances only on SPI_RECV
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= HDR_WAIT;
      r_hdr_addr <= '0;
      r_hdr_msb  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hdr_load) begin
        r_hdr_addr <= SPI_DATA[6:2];
        r_hdr_msb  <= SPI_DATA[1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_load   = 1'b0;
    w_push       = 1'b0;
    w_proto_err  = 1'b0;
    if (SPI_RECV) begin
      case (r_state)
        HDR_WAIT: begin
          if (SPI_DATA[7]) begin
            w_hdr_load   = 1'b1;
            w_state_next = DATA_WAIT;
          end else begin
            w_proto_err  = 1'b1;
          end
        end
        DATA_WAIT: begin
          if (SPI_DATA[7]) begin
            // A new header simply replaces the pending one.
            w_hdr_load   = 1'b1;
          end else begin
            w_push       = 1'b1;
            w_state_next = HDR_WAIT;
          end
        end
        default: w_state_next = HDR_WAIT;
      endcase
    end
  end

  // Bit 6 of the data byte is intentionally not part of the entry.
  assign w_push_entry = {r_hdr_addr, r_hdr_msb, SPI_DATA[5:0]};

  // FIFO control
  assign w_full    = (r_count == LP_DEPTH);
  assign w_empty   = (r_count == '0);
  // The !r_wr term keeps WR from ever being high two cycles in a row,
  // even if CLKen is held high.
  assign w_pop     = CLKen && !w_empty && !r_wr;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue stage: WR and the bus follow the pop by one cycle
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_dataw <= '0;
    end else begin
      r_wr <= w_pop;
      if (w_pop) begin
        {r_addr, r_dataw} <= r_mem[r_rd_ptr];
      end
    end
  end

  assign WR        = r_wr;
  assign ADDR      = r_addr;
  assign DATAW     = r_dataw;
  assign DBG_STATE = r_state;

`ifdef SID_BUS_STATUS_EN
  logic r_ovf, r_err;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_drop)      r_ovf <= 1'b1;
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  assign LEVEL = r_count;
  assign OVF   = r_ovf;
  assign ERR   = r_err;
`else
  logic w_unused_status;
  assign w_unused_status = w_drop | w_proto_err;
  assign LEVEL = '0;
  assign OVF   = 1'b0;
  assign ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_sid_spi_bus.sv
module tb_sid_spi_bus;

`ifdef SID_BUS_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RSTn;
  logic [7:0]  SPI_DATA;
  logic        SPI_RECV;
  logic        CLKen;
  logic        WR;
  logic [4:0]  ADDR;
  logic [7:0]  DATAW;
  logic [4:0]  LEVEL;
  logic        OVF;
  logic        ERR;
  logic        DBG_STATE;

  initial forever #5 CLK = ~CLK;

  sid_spi_bus #(.DEPTH(16), .AW(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .SPI_DATA(SPI_DATA), .SPI_RECV(SPI_RECV),
    .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATAW(DATAW), .LEVEL(LEVEL),
    .OVF(OVF), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [12:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] exp_of(input logic [7:0] h, input logic [7:0] d);
    return {h[6:2], h[1:0], d[5:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic prev_wr = 1'b0;
  always @(negedge CLK) begin
    if (RSTn && WR) begin
      logic [12:0] e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected addr=%0h data=%0h expected=none", ADDR, DATAW);
      end else begin
        e = exp_q.pop_front();
        if ({ADDR, DATAW} !== e) begin
          failures++;
          $display("FAIL wr_order actual=%0h expected=%0h", {ADDR, DATAW}, e);
        end
      end
      checks++;
      if (prev_wr) begin
        failures++;
        $display("FAIL wr_width actual=2cycles expected=1cycle");
      end
    end
    prev_wr = WR;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [7:0] d, input logic c);
    @(posedge CLK);
    #1;
    SPI_RECV = r;
    SPI_DATA = d;
    CLKen    = c;
  endtask

  task automatic send_write(input logic [7:0] h, input logic [7:0] d);
    drive(1'b1, h, 1'b0);
    drive(1'b1, d, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_clken();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] hdr;
    logic [7:0] data;
    logic [4:0] exp_addr;
    logic [7:0] exp_dataw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int wc0;
    vecs[0] = '{8'h86, 8'h15, 5'h01, 8'h95};
    vecs[1] = '{8'hFF, 8'h3F, 5'h1F, 8'hFF};
    vecs[2] = '{8'h80, 8'h00, 5'h00, 8'h00};
    vecs[3] = '{8'hFD, 8'h40, 5'h1F, 8'h40};
    vecs[4] = '{8'hC2, 8'h2A, 5'h10, 8'hAA};
    vecs[5] = '{8'h95, 8'h7F, 5'h05, 8'h7F};
    vecs[6] = '{8'hE0, 8'h01, 5'h18, 8'h01};

    RSTn = 1'b0; SPI_RECV = 1'b0; SPI_DATA = 8'h00; CLKen = 1'b0;
    #12;
    chk("rst_wr", WR, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_dataw", DATAW, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_err", ERR, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    idle(2);

    // Scenario 1: single write, CLKen every 12 cycles
    send_write(8'h86, 8'h15);
    exp_q.push_back({5'h01, 8'h95});
    @(negedge CLK);
    chk("s1_level_after_push", LEVEL, ST ? 1 : 0);
    chk("s1_state_hdr", DBG_STATE, 0);
    idle(11);
    pulse_clken();
    @(negedge CLK);
    chk("s1_wr", WR, 1);
    chk("s1_addr", ADDR, 5'h01);
    chk("s1_dataw", DATAW, 8'h95);
    chk("s1_level_after_pop", LEVEL, 0);
    @(negedge CLK);
    chk("s1_wr_low", WR, 0);
    chk("s1_addr_hold", ADDR, 5'h01);

    // Minimum latency: CLKen lands on the push cycle
    drive(1'b1, 8'h8C, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    exp_q.push_back({5'h03, 8'h22});
    drive(1'b0, 8'h00, 1'b1);
    @(negedge CLK);
    chk("lat_wr_early", WR, 0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    chk("lat_wr_min2", WR, 1);
    chk("lat_dataw", DATAW, 8'h22);
    idle(3);

    // Scenario 2: back-to-back writes, three successive CLKen ticks
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h0A, 1'b0);
    drive(1'b1, 8'h84, 1'b0);
    drive(1'b1, 8'h0B, 1'b0);
    drive(1'b1, 8'h88, 1'b0);
    drive(1'b1, 8'h0C, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    exp_q.push_back({5'h00, 8'h0A});
    exp_q.push_back({5'h01, 8'h0B});
    exp_q.push_back({5'h02, 8'h0C});
    @(negedge CLK);
    chk("s2_level3", LEVEL, ST ? 3 : 0);
    wc0 = wr_count;
    repeat (3) begin
      idle(11);
      pulse_clken();
    end
    idle(2);
    chk("s2_wr_count", wr_count - wc0, 3);
    chk("s2_queue_empty", exp_q.size(), 0);

    // Table-driven decode vectors
    for (int i = 0; i < 7; i++) begin
      send_write(vecs[i].hdr, vecs[i].data);
      exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_dataw});
      pulse_clken();
      @(negedge CLK);
      chk($sformatf("vec%0d_wr", i), WR, 1);
      chk($sformatf("vec%0d_addr", i), ADDR, vecs[i].exp_addr);
      chk($sformatf("vec%0d_dataw", i), DATAW, vecs[i].exp_dataw);
      idle(2);
    end

    // Scenario 4: data byte with no header, then header replacement
    drive(1'b1, 8'h3F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    chk("s4_err", ERR, ST);
    chk("s4_no_push", LEVEL, 0);
    wc0 = wr_count;
    pulse_clken();
    idle(2);
    chk("s4_no_wr", wr_count - wc0, 0);
    drive(1'b1, 8'h80, 1'b0);
    drive(1'b1, 8'h84, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    exp_q.push_back({5'h01, 8'h01});
    pulse_clken();
    @(negedge CLK);
    chk("s4_wr", WR, 1);
    chk("s4_addr", ADDR, 5'h01);
    chk("s4_dataw", DATAW, 8'h01);
    idle(2);

    // Scenario 5: push coinciding with pop while full
    for (int i = 0; i < 16; i++) begin
      logic [7:0] h, d;
      h = 8'(8'h80 | (i << 2));
      d = 8'(i + 8'h10);
      send_write(h, d);
      exp_q.push_back(exp_of(h, d));
    end
    @(negedge CLK);
    chk("s5_level_full", LEVEL, ST ? 16 : 0);
    drive(1'b1, 8'h90, 1'b0);
    drive(1'b1, 8'h2C, 1'b1);
    exp_q.push_back({5'h04, 8'h2C});
    drive(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    chk("s5_level_stays", LEVEL, ST ? 16 : 0);
    chk("s5_ovf_clear", OVF, 0);
    chk("s5_wr", WR, 1);
    repeat (16) begin
      idle(3);
      pulse_clken();
    end
    idle(2);
    chk("s5_drained", exp_q.size(), 0);
    chk("s5_level_zero", LEVEL, 0);

    // Scenario 3: 17 writes with CLKen held low
    for (int i = 0; i < 17; i++) begin
      logic [7:0] h, d;
      h = 8'(8'h80 | (i << 2));
      d = 8'(i + 8'h20);
      send_write(h, d);
      if (i < 16) exp_q.push_back(exp_of(h, d));
    end
    @(negedge CLK);
    chk("s3_level", LEVEL, ST ? 16 : 0);
    chk("s3_ovf", OVF, ST);
    wc0 = wr_count;
    repeat (17) begin
      idle(11);
      pulse_clken();
    end
    idle(2);
    chk("s3_issued16", wr_count - wc0, 16);
    chk("s3_queue_empty", exp_q.size(), 0);
    chk("s3_level_zero", LEVEL, 0);

    // Scenario 6: reset mid-burst with queued writes and a latched header
    for (int i = 0; i < 6; i++) begin
      logic [7:0] h;
      h = 8'(8'h83 | ((i + 1) << 2));
      send_write(h, 8'h3F);
    end
    drive(1'b1, 8'h86, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    #2;
    chk("s6_pre_wr", WR, 1);
    chk("s6_pre_dataw", DATAW, 8'hFF);
    chk("s6_pre_level", LEVEL, ST ? 5 : 0);
    chk("s6_pre_state", DBG_STATE, 1);
    RSTn = 1'b0;
    #1;
    chk("s6_rst_wr", WR, 0);
    chk("s6_rst_addr", ADDR, 0);
    chk("s6_rst_dataw", DATAW, 0);
    chk("s6_rst_level", LEVEL, 0);
    chk("s6_rst_ovf", OVF, 0);
    chk("s6_rst_err", ERR, 0);
    exp_q.delete();
    @(negedge CLK);
    #2;
    RSTn = 1'b1;
    drive(1'b1, 8'h15, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    chk("s6_err", ERR, ST);
    chk("s6_level", LEVEL, 0);
    wc0 = wr_count;
    repeat (2) begin
      idle(11);
      pulse_clken();
    end
    idle(2);
    chk("s6_no_wr", wr_count - wc0, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
